alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Operand-fetch/issue stage directly upstream of the integer ALU.
- Accepts one decoded instruction per cycle over a valid/ready handshake. Holds the 64x32 architectural register file, bypasses the ALU and memory write-back ports, and stalls on hazards using a small scoreboard.
- Drives the ALU's ope/ds_val/dt_val/dd/imm inputs from registers. Consumes the ALU's registered reg_addr/reg_dd_val as its write-back port.

Parameters:
- NREG, 64, number of architectural registers; register index width is 6.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_ope  in  6  ALU opcode
- in_ds  in  6  source register s
- in_dt  in  6  source register t
- in_dd  in  6  destination register
- in_imm  in  16  immediate
- alu_ope  out  6  to ALU ope
- alu_ds_val  out  32  to ALU ds_val
- alu_dt_val  out  32  to ALU dt_val
- alu_dd  out  6  to ALU dd
- alu_imm  out  16  to ALU imm
- wb_alu_addr  in  6  ALU result register; 0 = no write
- wb_alu_val  in  32  ALU result
- mem_issue_en  in  1  a load to mem_issue_dd was issued elsewhere this cycle
- mem_issue_dd  in  6  load destination
- wb_mem_en  in  1  load write-back strobe
- wb_mem_addr  in  6  load write-back register
- wb_mem_val  in  32  load data

Behaviour:
- Reset (rstn=0 at a clk edge):
  - all alu_* outputs become 0; opcode 0 is the NOP bubble.
  - All 64 registers are cleared and the load scoreboard is cleared.
  - in_ready is 0 while rstn=0.
- Register r0:
  - Reads return 0.
  - Writes to r0 are discarded and r0 is never marked pending.
- Register-form ops (ADD 001100, SUB 010100, SLL 011100, SRL 100100, SRA 101100) read ds and dt.
- All other ops read ds only. LUI reads ds because the ALU uses ds_val[15:0].
- dt is ignored for the hazard check on non-register-form ops.
- Hazard (stall):
  - A used source is nonzero and equals alu_dd. This is the in-flight ALU op; the result is not yet registered.
  - Or a used source has its scoreboard bit set.
  - Or in_dd is nonzero and has its scoreboard bit set (WAW against an outstanding load).
- Handshake:
  - in_ready = rstn & ~hazard. This is combinational from the in_* inputs and registered state.
  - Transfer happens when in_valid & in_ready at a clk edge.
  - On transfer: alu_ope/alu_dd/alu_imm are loaded from the input, and alu_ds_val/alu_dt_val from the operand read.
  - Otherwise alu_ope and alu_dd become 0 (bubble); alu_ds_val/alu_dt_val/alu_imm hold.
  - Latency: issue edge to ALU input = 1 cycle.
  - A dependent back-to-back op costs exactly one bubble: the producer issues at edge N, the consumer stalls, then issues at edge N+2.
- Operand read priority, highest first:
  - index 0 gives 0;
  - wb_mem_en & wb_mem_addr match gives wb_mem_val;
  - wb_alu_addr match gives wb_alu_val;
  - otherwise the register file.
- Register-file write every edge:
  - wb_alu_addr != 0 writes wb_alu_val.
  - wb_mem_en & wb_mem_addr != 0 writes wb_mem_val.
  - Same address on both ports: the mem value is stored.
- Scoreboard:
  - mem_issue_en sets bit[mem_issue_dd].
  - wb_mem_en clears bit[wb_mem_addr].
  - Set and clear of the same bit in the same cycle: set wins.
  - A load write-back in the same cycle as a dependent instruction: the scoreboard bit still reads set, so the instruction stalls one cycle.
- Reset mid-stall discards the held instruction. Upstream must re-present it.

Decomposition:
- Shared package holds:
  - the opcode constants (OPE_NOP=0, LUI, ADD, ADDI, SUB, SLL, SLLI, SRL, SRLI, SRA, SRAI);
  - a function is_rform(ope);
  - REG_W=6 and XLEN.
- One sub-module, regfile_2r2w, provides 64x32 storage with 2 async read ports, 2 write ports, mem-priority on the same address, r0 forced to 0 and sync clear.
- Bypass, hazard logic and the scoreboard live in alu_issue.

Test Plan:
- Reset, then issue ADDI r1,r0,5 -> next cycle alu_ope=001000, alu_dd=1, alu_ds_val=0, alu_imm=5. Two cycles later feed wb_alu_addr=1, wb_alu_val=5 -> the register file holds r1=5.
- Dependent ops: ADDI r1 then ADD r2,r1,r1 on consecutive cycles -> in_ready=0 for exactly one cycle. ADD then issues with alu_ds_val=alu_dt_val=5, bypassed from wb_alu_val.
- Load hazard: mem_issue_en with dd=7, then SLL r3,r7,r2 held valid -> in_ready stays 0 until wb_mem_en with addr 7 and val 0x80000000. It issues the following cycle with ds_val=0x80000000.
- WAW: load to r4 pending, then ADDI r4 -> stalls until wb_mem_en addr 4. Same-cycle mem_issue_en and wb_mem_en on r9 -> bit stays set.
- r0 and priority: wb_alu addr 0 with val 0xDEAD -> reads of r0 still return 0. Simultaneous wb_alu and wb_mem to r6 (values 1 and 2) -> operand and stored value are 2.
- Reset asserted during a stall -> alu_ope=0, scoreboard clear, register file zero; after release in_ready=1 for any instruction.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU operand-fetch/issue stage:
// opcode encodings, widths and the register-form decode helper.
package alu_issue_pkg;

    localparam int NREG  = 64;
    localparam int REG_W = 6;
    localparam int XLEN  = 32;

    localparam logic [5:0] OPE_NOP  = 6'b000000;
    localparam logic [5:0] OPE_LUI  = 6'b000100;
    localparam logic [5:0] OPE_ADDI = 6'b001000;
    localparam logic [5:0] OPE_ADD  = 6'b001100;
    localparam logic [5:0] OPE_SUB  = 6'b010100;
    localparam logic [5:0] OPE_SLLI = 6'b011000;
    localparam logic [5:0] OPE_SLL  = 6'b011100;
    localparam logic [5:0] OPE_SRLI = 6'b100000;
    localparam logic [5:0] OPE_SRL  = 6'b100100;
    localparam logic [5:0] OPE_SRAI = 6'b101000;
    localparam logic [5:0] OPE_SRA  = 6'b101100;

    // Register-form ops are the only ones that consume dt.
    function automatic logic is_rform(input logic [5:0] ope);
        return ope inside {OPE_ADD, OPE_SUB, OPE_SLL, OPE_SRL, OPE_SRA};
    endfunction

endpackage

// File: rtl/alu_issue_regfile_2r2w.sv
// 64x32 architectural register file: two async reads, two writes,
// port b (load data) wins on a shared address, r0 hardwired to zero.
module regfile_2r2w
    import alu_issue_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic [REG_W-1:0] ra0_i,
    input  logic [REG_W-1:0] ra1_i,
    output logic [XLEN-1:0]  rd0_o,
    output logic [XLEN-1:0]  rd1_o,
    input  logic             wea_i,
    input  logic [REG_W-1:0] waa_i,
    input  logic [XLEN-1:0]  wda_i,
    input  logic             web_i,
    input  logic [REG_W-1:0] wab_i,
    input  logic [XLEN-1:0]  wdb_i
);

    logic [XLEN-1:0] mem_q [NREG];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wea_i && waa_i != '0) begin
                mem_q[waa_i] <= wda_i;
            end
            if (web_i && wab_i != '0) begin
                mem_q[wab_i] <= wdb_i;
            end
        end
    end

    assign rd0_o = (ra0_i == '0) ? '0 : mem_q[ra0_i];
    assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];

endmodule

// File: rtl/alu_issue.sv
// Operand fetch / issue stage ahead of the integer ALU: register read
// with write-back bypass, load scoreboard and hazard stall.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_ope,
    input  logic [5:0]  in_ds,
    input  logic [5:0]  in_dt,
    input  logic [5:0]  in_dd,
    input  logic [15:0] in_imm,
    output logic [5:0]  alu_ope,
    output logic [31:0] alu_ds_val,
    output logic [31:0] alu_dt_val,
    output logic [5:0]  alu_dd,
    output logic [15:0] alu_imm,
    input  logic [5:0]  wb_alu_addr,
    input  logic [31:0] wb_alu_val,
    input  logic        mem_issue_en,
    input  logic [5:0]  mem_issue_dd,
    input  logic        wb_mem_en,
    input  logic [5:0]  wb_mem_addr,
    input  logic [31:0] wb_mem_val
);

    logic [5:0]      ope_q, ope_d, dd_q, dd_d;
    logic [15:0]     imm_q, imm_d;
    logic [XLEN-1:0] dsv_q, dsv_d, dtv_q, dtv_d;
    logic [NREG-1:0] sb_q, sb_d;
    logic [XLEN-1:0] rf_ds, rf_dt, ds_val, dt_val;
    logic            use_dt, haz_ds, haz_dt, haz_dd, hazard, fire;

    regfile_2r2w u_rf (
        .clk   (clk),
        .rstn  (rstn),
        .ra0_i (in_ds),
        .ra1_i (in_dt),
        .rd0_o (rf_ds),
        .rd1_o (rf_dt),
        .wea_i (wb_alu_addr != '0),
        .waa_i (wb_alu_addr),
        .wda_i (wb_alu_val),
        .web_i (wb_mem_en),
        .wab_i (wb_mem_addr),
        .wdb_i (wb_mem_val)
    );

    function automatic logic [XLEN-1:0] fwd(
        input logic [REG_W-1:0] idx,
        input logic [XLEN-1:0]  rf,
        input logic             m_en,
        input logic [REG_W-1:0] m_a,
        input logic [XLEN-1:0]  m_v,
        input logic [REG_W-1:0] a_a,
        input logic [XLEN-1:0]  a_v
    );
        if (idx == '0)             return '0;
        else if (m_en && m_a == idx) return m_v;
        else if (a_a == idx)       return a_v;
        else                       return rf;
    endfunction

    always_comb begin
        ds_val = fwd(in_ds, rf_ds, wb_mem_en, wb_mem_addr,
                     wb_mem_val, wb_alu_addr, wb_alu_val);
        dt_val = fwd(in_dt, rf_dt, wb_mem_en, wb_mem_addr,
                     wb_mem_val, wb_alu_addr, wb_alu_val);
    end

    // The in-flight op's result is not registered yet, hence the dd_q match.
    always_comb begin
        use_dt   = is_rform(in_ope);
        haz_ds   = (in_ds != '0 && in_ds == dd_q) || sb_q[in_ds];
        haz_dt   = use_dt &&
                   ((in_dt != '0 && in_dt == dd_q) || sb_q[in_dt]);
        haz_dd   = (in_dd != '0) && sb_q[in_dd];
        hazard   = haz_ds || haz_dt || haz_dd;
        in_ready = rstn && !hazard;
        fire     = in_valid && in_ready;
    end

    always_comb begin
        ope_d = OPE_NOP;
        dd_d  = '0;
        imm_d = imm_q;
        dsv_d = dsv_q;
        dtv_d = dtv_q;
        if (fire) begin
            ope_d = in_ope;
            dd_d  = in_dd;
            imm_d = in_imm;
            dsv_d = ds_val;
            dtv_d = dt_val;
        end
    end

    // A set and clear of the same bit in one cycle leaves it set.
    always_comb begin
        sb_d = sb_q;
        if (wb_mem_en) begin
            sb_d[wb_mem_addr] = 1'b0;
        end
        if (mem_issue_en) begin
            sb_d[mem_issue_dd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ope_q <= '0;
            dd_q  <= '0;
            imm_q <= '0;
            dsv_q <= '0;
            dtv_q <= '0;
            sb_q  <= '0;
        end else begin
            ope_q <= ope_d;
            dd_q  <= dd_d;
            imm_q <= imm_d;
            dsv_q <= dsv_d;
            dtv_q <= dtv_d;
            sb_q  <= sb_d;
        end
    end

    assign alu_ope    = ope_q;
    assign alu_dd     = dd_q;
    assign alu_imm    = imm_q;
    assign alu_ds_val = dsv_q;
    assign alu_dt_val = dtv_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: issue, bypass, load hazards,
// r0 handling, write-port priority and reset during a stall.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_ope, in_ds, in_dt, in_dd;
    logic [15:0] in_imm;
    logic [5:0]  alu_ope, alu_dd;
    logic [31:0] alu_ds_val, alu_dt_val;
    logic [15:0] alu_imm;
    logic [5:0]  wb_alu_addr;
    logic [31:0] wb_alu_val;
    logic        mem_issue_en;
    logic [5:0]  mem_issue_dd;
    logic        wb_mem_en;
    logic [5:0]  wb_mem_addr;
    logic [31:0] wb_mem_val;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ADD  = 6'b001100;
    localparam logic [5:0] SUB  = 6'b010100;
    localparam logic [5:0] SLL  = 6'b011100;

    alu_issue dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ope       (in_ope),
        .in_ds        (in_ds),
        .in_dt        (in_dt),
        .in_dd        (in_dd),
        .in_imm       (in_imm),
        .alu_ope      (alu_ope),
        .alu_ds_val   (alu_ds_val),
        .alu_dt_val   (alu_dt_val),
        .alu_dd       (alu_dd),
        .alu_imm      (alu_imm),
        .wb_alu_addr  (wb_alu_addr),
        .wb_alu_val   (wb_alu_val),
        .mem_issue_en (mem_issue_en),
        .mem_issue_dd (mem_issue_dd),
        .wb_mem_en    (wb_mem_en),
        .wb_mem_addr  (wb_mem_addr),
        .wb_mem_val   (wb_mem_val)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [5:0] ope,
                       input logic [5:0] ds, input logic [5:0] dt,
                       input logic [5:0] dd, input logic [15:0] imm);
        in_valid = v;
        in_ope   = ope;
        in_ds    = ds;
        in_dt    = dt;
        in_dd    = dd;
        in_imm   = imm;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        put(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 16'd0);
        wb_alu_addr = '0; wb_alu_val = '0;
        mem_issue_en = 1'b0; mem_issue_dd = '0;
        wb_mem_en = 1'b0; wb_mem_addr = '0; wb_mem_val = '0;
        tick();
        tick();
        chk("rst_ope", {26'd0, alu_ope}, 32'h0);
        chk("rst_dd", {26'd0, alu_dd}, 32'h0);
        chk("rst_ds_val", alu_ds_val, 32'h0);
        chk("rst_imm", {16'd0, alu_imm}, 32'h0);
        chk("rst_ready", {31'd0, in_ready}, 32'h0);
        rstn = 1'b1;
        tick();
        chk("idle_ready", {31'd0, in_ready}, 32'h1);

        // ADDI r1,r0,5 then dependent ADD r2,r1,r1
        put(1'b1, ADDI, 6'd0, 6'd0, 6'd1, 16'd5);
        #1 chk("addi_ready", {31'd0, in_ready}, 32'h1);
        tick();
        chk("addi_ope", {26'd0, alu_ope}, 32'h08);
        chk("addi_dd", {26'd0, alu_dd}, 32'h1);
        chk("addi_ds_val", alu_ds_val, 32'h0);
        chk("addi_imm", {16'd0, alu_imm}, 32'h5);
        put(1'b1, ADD, 6'd1, 6'd1, 6'd2, 16'd0);
        #1 chk("dep_stall", {31'd0, in_ready}, 32'h0);
        tick();
        chk("dep_bubble", {26'd0, alu_ope}, 32'h0);
        wb_alu_addr = 6'd1; wb_alu_val = 32'd5;
        #1 chk("dep_ready", {31'd0, in_ready}, 32'h1);
        tick();
        chk("dep_ope", {26'd0, alu_ope}, 32'h0c);
        chk("dep_dd", {26'd0, alu_dd}, 32'h2);
        chk("dep_ds_byp", alu_ds_val, 32'd5);
        chk("dep_dt_byp", alu_dt_val, 32'd5);
        wb_alu_addr = '0; wb_alu_val = '0;
        put(1'b1, SUB, 6'd1, 6'd0, 6'd5, 16'd0);
        tick();
        chk("rf_r1", alu_ds_val, 32'd5);
        put(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 16'd0);

        // load to r7, SLL r3,r7,r2 waits for its data
        mem_issue_en = 1'b1; mem_issue_dd = 6'd7;
        tick();
        mem_issue_en = 1'b0;
        put(1'b1, SLL, 6'd7, 6'd2, 6'd3, 16'd0);
        #1 chk("ld_stall0", {31'd0, in_ready}, 32'h0);
        tick();
        chk("ld_stall1", {31'd0, in_ready}, 32'h0);
        chk("ld_bubble", {26'd0, alu_ope}, 32'h0);
        wb_mem_en = 1'b1; wb_mem_addr = 6'd7; wb_mem_val = 32'h8000_0000;
        #1 chk("ld_wb_stall", {31'd0, in_ready}, 32'h0);
        tick();
        wb_mem_en = 1'b0;
        #1 chk("ld_ready", {31'd0, in_ready}, 32'h1);
        tick();
        chk("ld_ope", {26'd0, alu_ope}, 32'h1c);
        chk("ld_ds_val", alu_ds_val, 32'h8000_0000);
        chk("ld_dt_val", alu_dt_val, 32'h0);
        put(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 16'd0);

        // WAW against outstanding load to r4
        mem_issue_en = 1'b1; mem_issue_dd = 6'd4;
        tick();
        mem_issue_en = 1'b0;
        put(1'b1, ADDI, 6'd0, 6'd0, 6'd4, 16'd3);
        #1 chk("waw_stall0", {31'd0, in_ready}, 32'h0);
        tick();
        chk("waw_stall1", {31'd0, in_ready}, 32'h0);
        wb_mem_en = 1'b1; wb_mem_addr = 6'd4; wb_mem_val = 32'h44;
        tick();
        wb_mem_en = 1'b0;
        #1 chk("waw_ready", {31'd0, in_ready}, 32'h1);
        tick();
        chk("waw_dd", {26'd0, alu_dd}, 32'h4);
        put(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 16'd0);

        // same-cycle set and clear of r9 keeps it pending
        mem_issue_en = 1'b1; mem_issue_dd = 6'd9;
        wb_mem_en = 1'b1; wb_mem_addr = 6'd9; wb_mem_val = 32'h99;
        tick();
        mem_issue_en = 1'b0; wb_mem_en = 1'b0;
        put(1'b1, ADDI, 6'd9, 6'd0, 6'd10, 16'd0);
        #1 chk("sb_setwins", {31'd0, in_ready}, 32'h0);
        put(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 16'd0);
        wb_mem_en = 1'b1; wb_mem_addr = 6'd9; wb_mem_val = 32'h99;
        tick();
        wb_mem_en = 1'b0;

        // r0 ignores writes and bypass
        wb_alu_addr = 6'd0; wb_alu_val = 32'hDEAD;
        tick();
        put(1'b1, ADD, 6'd0, 6'd0, 6'd11, 16'd0);
        #1 chk("r0_ready", {31'd0, in_ready}, 32'h1);
        tick();
        wb_alu_addr = '0; wb_alu_val = '0;
        chk("r0_ds", alu_ds_val, 32'h0);
        chk("r0_dt", alu_dt_val, 32'h0);

        // both write ports on r6: load data wins
        wb_alu_addr = 6'd6; wb_alu_val = 32'd1;
        wb_mem_en = 1'b1; wb_mem_addr = 6'd6; wb_mem_val = 32'd2;
        put(1'b1, ADD, 6'd6, 6'd0, 6'd12, 16'd0);
        tick();
        chk("prio_byp", alu_ds_val, 32'd2);
        wb_alu_addr = '0; wb_alu_val = '0; wb_mem_en = 1'b0;
        put(1'b1, ADD, 6'd6, 6'd6, 6'd13, 16'd0);
        tick();
        chk("prio_rf_ds", alu_ds_val, 32'd2);
        chk("prio_rf_dt", alu_dt_val, 32'd2);
        put(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 16'd0);
        tick();

        // reset while a stalled instruction is held
        mem_issue_en = 1'b1; mem_issue_dd = 6'd7;
        put(1'b1, ADDI, 6'd0, 6'd0, 6'd1, 16'd9);
        tick();
        mem_issue_en = 1'b0;
        put(1'b1, SLL, 6'd7, 6'd1, 6'd3, 16'd0);
        #1 chk("rs_stall", {31'd0, in_ready}, 32'h0);
        rstn = 1'b0;
        #1 chk("rs_ready_low", {31'd0, in_ready}, 32'h0);
        tick();
        chk("rs_ope", {26'd0, alu_ope}, 32'h0);
        chk("rs_dd", {26'd0, alu_dd}, 32'h0);
        chk("rs_imm", {16'd0, alu_imm}, 32'h0);
        rstn = 1'b1;
        #1 chk("rs_ready", {31'd0, in_ready}, 32'h1);
        tick();
        chk("rs_issue", {26'd0, alu_ope}, 32'h1c);
        chk("rs_r7_clr", alu_ds_val, 32'h0);
        chk("rs_r1_clr", alu_dt_val, 32'h0);
        put(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 16'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
